// File: rtl/fetch_unit.sv
// fetch_unit: datapath-side fetch engine.
// Owns PC, IR and STAT, and fetches one instruction per PC_WRITE rising edge
// over a single-outstanding req/ack handshake to instruction memory.
// Branch targets are either absolute (taken from IR) or PC-relative
// (PC plus the sign-extended low OFF_W bits of IR).
module fetch_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              PC_RST,
  input  logic              PC_WRITE,
  input  logic              PC_SEL,
  input  logic              BR_SEL,
  input  logic              STAT_WE,
  input  logic [3:0]        ALU_FLAGS,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  input  logic              IMEM_ACK,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [3:0]        OPCODE,
  output logic [3:0]        MM,
  output logic [3:0]        STAT,
  output logic              FETCH_BUSY,
  output logic              OVERRUN
);

  // Fetch sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Address of the next instruction. The very first fetch after a clear always
  // goes to address 0 regardless of the select lines. All arithmetic wraps
  // modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic              first,
    input logic              pc_sel,
    input logic              br_sel,
    input logic [ADDR_W-1:0] pc,
    input logic [DATA_W-1:0] ir
  );
    logic signed [OFF_W-1:0] off;
    logic [ADDR_W-1:0]       off_ext;
    off     = ir[OFF_W-1:0];
    off_ext = ADDR_W'(off);
    if (first) begin
      next_addr = {ADDR_W{1'b0}};
    end else if (!pc_sel) begin
      next_addr = pc + ADDR_W'(1);
    end else if (!br_sel) begin
      next_addr = ir[ADDR_W-1:0];
    end else begin
      next_addr = pc + off_ext;
    end
  endfunction

  // Registered state
  logic [1:0]        state_r;
  logic              pw_q_r;
  logic              first_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] ir_r;
  logic [3:0]        stat_r;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic              busy_r;
  logic              ovr_r;

  // Next-state values
  logic              start_s;
  logic [ADDR_W-1:0] nxt_s;
  logic [1:0]        state_nxt_s;
  logic              first_nxt_s;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [DATA_W-1:0] ir_nxt_s;
  logic              req_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              busy_nxt_s;
  logic              ovr_nxt_s;
  logic [3:0]        stat_nxt_s;

  // Rising-edge detect on PC_WRITE and target computation for a new fetch
  always_comb begin
    start_s = PC_WRITE & ~pw_q_r;
    nxt_s   = next_addr(first_r, PC_SEL, BR_SEL, pc_r, ir_r);
  end

  // Fetch sequencer: start in IDLE, wait for ack in REQ, one quiet cycle in HOLD
  always_comb begin
    state_nxt_s = state_r;
    first_nxt_s = first_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    req_nxt_s   = req_r;
    addr_nxt_s  = addr_r;
    busy_nxt_s  = busy_r;
    ovr_nxt_s   = ovr_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          addr_nxt_s  = nxt_s;
          req_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A new request while one is outstanding is dropped and flagged
        if (start_s) begin
          ovr_nxt_s = 1'b1;
        end else begin
          ovr_nxt_s = ovr_r;
        end
        if (IMEM_ACK) begin
          ir_nxt_s    = IMEM_RDATA;
          pc_nxt_s    = addr_r;
          req_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b0;
          first_nxt_s = 1'b0;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (start_s) begin
          ovr_nxt_s = 1'b1;
        end else begin
          ovr_nxt_s = ovr_r;
        end
        state_nxt_s = ST_IDLE;
      end
      default: begin
        req_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Status register: independent of fetch activity
  always_comb begin
    if (STAT_WE) begin
      stat_nxt_s = ALU_FLAGS;
    end else begin
      stat_nxt_s = stat_r;
    end
  end

  // State update: async reset, then synchronous PC_RST clear, then normal load
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_r <= ST_IDLE;
      pw_q_r  <= 1'b0;
      first_r <= 1'b1;
      pc_r    <= {ADDR_W{1'b0}};
      ir_r    <= {DATA_W{1'b0}};
      stat_r  <= 4'h0;
      req_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (PC_RST) begin
      state_r <= ST_IDLE;
      pw_q_r  <= 1'b0;
      first_r <= 1'b1;
      pc_r    <= {ADDR_W{1'b0}};
      ir_r    <= {DATA_W{1'b0}};
      stat_r  <= 4'h0;
      req_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pw_q_r  <= PC_WRITE;
      first_r <= first_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      stat_r  <= stat_nxt_s;
      req_r   <= req_nxt_s;
      addr_r  <= addr_nxt_s;
      busy_r  <= busy_nxt_s;
      ovr_r   <= ovr_nxt_s;
    end
  end

  // Output mapping; decode fields come straight from IR
  always_comb begin
    IMEM_REQ   = req_r;
    IMEM_ADDR  = addr_r;
    PC         = pc_r;
    IR         = ir_r;
    OPCODE     = ir_r[DATA_W-1 -: 4];
    MM         = ir_r[DATA_W-5 -: 4];
    STAT       = stat_r;
    FETCH_BUSY = busy_r;
    OVERRUN    = ovr_r;
  end

endmodule
